// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared FSM state type and winner encodings for the score logic.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HOLD      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_timer
// Brief    : Loadable down-counter; o_done is high while enabled at zero.
// Revision : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = i_en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/score_controller.sv
`default_nettype none
// ============================================================================
// Module   : score_controller
// Brief    : Pong scoring FSM (IDLE/PLAY/HOLD/GAME_OVER) with registered outputs.
//            Define SCORE_BLINK_EN to blink the score digits in GAME_OVER.
// Revision : 1.0 - initial release
// ============================================================================
module score_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       play_en,
    output logic       serve_dir,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       digits_on
);

    localparam int              c_HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_HOLD_W-1:0] c_hold_load = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      c_win       = 4'(WIN_SCORE);

    state_t     r_state, w_next_state;
    logic [3:0] r_num1, r_num2, w_num1, w_num2;
    logic       r_play_en, r_serve_dir, r_game_over, w_serve_dir;
    logic [1:0] r_winner, w_winner;
    logic       w_hold_load, w_hold_done;

    hold_timer #(.W(c_HOLD_W)) u_hold_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_hold_load),
        .i_load_val (c_hold_load),
        .i_en       (r_state == HOLD),
        .o_done     (w_hold_done)
    );

    // start outranks every point pulse, in every state
    always_comb begin
        w_next_state = r_state;
        w_num1       = r_num1;
        w_num2       = r_num2;
        w_serve_dir  = r_serve_dir;
        w_winner     = r_winner;
        w_hold_load  = 1'b0;
        if (start) begin
            w_next_state = PLAY;
            w_num1       = 4'd0;
            w_num2       = 4'd0;
            w_serve_dir  = 1'b0;
            w_winner     = WINNER_NONE;
        end else begin
            case (r_state)
                PLAY: begin
                    if (p1_point && p2_point) begin
                        w_next_state = HOLD;
                        w_hold_load  = 1'b1;
                    end else if (p1_point) begin
                        w_serve_dir = 1'b1;
                        if (r_num1 < c_win) w_num1 = r_num1 + 4'd1;
                        if (w_num1 == c_win) begin
                            w_next_state = GAME_OVER;
                            w_winner     = WINNER_P1;
                        end else begin
                            w_next_state = HOLD;
                            w_hold_load  = 1'b1;
                        end
                    end else if (p2_point) begin
                        w_serve_dir = 1'b0;
                        if (r_num2 < c_win) w_num2 = r_num2 + 4'd1;
                        if (w_num2 == c_win) begin
                            w_next_state = GAME_OVER;
                            w_winner     = WINNER_P2;
                        end else begin
                            w_next_state = HOLD;
                            w_hold_load  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_hold_done) w_next_state = PLAY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_num1      <= 4'd0;
            r_num2      <= 4'd0;
            r_play_en   <= 1'b0;
            r_serve_dir <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WINNER_NONE;
        end else begin
            r_state     <= w_next_state;
            r_num1      <= w_num1;
            r_num2      <= w_num2;
            r_play_en   <= (w_next_state == PLAY);
            r_serve_dir <= w_serve_dir;
            r_game_over <= (w_next_state == GAME_OVER);
            r_winner    <= w_winner;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int              c_BLINK_W    = $clog2(BLINK_CYCLES + 1);
    localparam logic [c_BLINK_W-1:0] c_blink_load = c_BLINK_W'(BLINK_CYCLES - 1);

    logic w_blink_load, w_blink_done, r_digits_on;

    // reload on entry and on every half-period boundary while in GAME_OVER
    assign w_blink_load = (w_next_state == GAME_OVER) &&
                          ((r_state != GAME_OVER) || w_blink_done);

    hold_timer #(.W(c_BLINK_W)) u_blink_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_blink_load),
        .i_load_val (c_blink_load),
        .i_en       (r_state == GAME_OVER),
        .o_done     (w_blink_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digits_on <= 1'b1;
        end else if ((w_next_state != GAME_OVER) || (r_state != GAME_OVER)) begin
            r_digits_on <= 1'b1;
        end else if (w_blink_done) begin
            r_digits_on <= ~r_digits_on;
        end
    end

    assign digits_on = r_digits_on;
`else
    assign digits_on = 1'b1;
`endif

    assign num1      = r_num1;
    assign num2      = r_num2;
    assign play_en   = r_play_en;
    assign serve_dir = r_serve_dir;
    assign game_over = r_game_over;
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_controller
// Brief    : Scoreboard bench for score_controller (WIN=3, HOLD=5, BLINK=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_controller;

    localparam int WIN   = 3;
    localparam int HOLD  = 5;
    localparam int BLINK = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [3:0] num1, num2;
    logic       play_en, serve_dir, game_over, digits_on;
    logic [1:0] winner;

    typedef struct packed {
        logic [3:0] n1;
        logic [3:0] n2;
        logic       pe;
        logic       sd;
        logic       go;
        logic [1:0] w;
        logic       dg;
    } obs_t;

    obs_t q[$];
    int   total = 0;
    int   bad   = 0;

    score_controller #(
        .WIN_SCORE    (WIN),
        .HOLD_CYCLES  (HOLD),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .p1_point  (p1_point),
        .p2_point  (p2_point),
        .num1      (num1),
        .num2      (num2),
        .play_en   (play_en),
        .serve_dir (serve_dir),
        .game_over (game_over),
        .winner    (winner),
        .digits_on (digits_on)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return obs_t'({num1, num2, play_en, serve_dir, game_over, winner, digits_on});
    endfunction

    function automatic obs_t mk(input logic [3:0] n1, input logic [3:0] n2, input logic pe,
                                input logic sd, input logic go, input logic [1:0] w,
                                input logic dg);
        return obs_t'({n1, n2, pe, sd, go, w, dg});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b0; start = 1'b1; p1_point = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        start = 1'b0; p1_point = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL reset: actual=%h required=%h", o, e); end
        rst_n = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL idle: actual=%h required=%h", o, e); end
    endtask

    task automatic test_point();
        obs_t e, o;
        start = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        start = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL start: actual=%h required=%h", o, e); end
        p1_point = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            q.push_back(mk(4'd1, 4'd0, (i == HOLD), 1'b1, 1'b0, 2'b00, 1'b1));
            tick();
            p1_point = 1'b0;
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL p1_hold[%0d]: actual=%h required=%h", i, o, e); end
        end
    endtask

    task automatic test_hold_ignore();
        obs_t e, o;
        p2_point = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            p1_point = (i == 1);
            q.push_back(mk(4'd1, 4'd1, (i == HOLD), 1'b0, 1'b0, 2'b00, 1'b1));
            tick();
            p1_point = 1'b0; p2_point = 1'b0;
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL hold_ignore[%0d]: actual=%h required=%h", i, o, e); end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, o;
        p1_point = 1'b1; p2_point = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            q.push_back(mk(4'd1, 4'd1, (i == HOLD), 1'b0, 1'b0, 2'b00, 1'b1));
            tick();
            p1_point = 1'b0; p2_point = 1'b0;
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL simultaneous[%0d]: actual=%h required=%h", i, o, e); end
        end
    endtask

    task automatic test_restart();
        obs_t e, o;
        p1_point = 1'b1;
        for (int i = 0; i <= HOLD; i++) begin
            q.push_back(mk(4'd2, 4'd1, (i == HOLD), 1'b1, 1'b0, 2'b00, 1'b1));
            tick();
            p1_point = 1'b0;
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL to_two[%0d]: actual=%h required=%h", i, o, e); end
        end
        start = 1'b1; p2_point = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        start = 1'b0; p2_point = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL restart: actual=%h required=%h", o, e); end
    endtask

    task automatic test_win();
        obs_t e, o;
        logic [15:0] pat;
`ifdef SCORE_BLINK_EN
        pat = 16'b1111000011110000;
`else
        pat = 16'hFFFF;
`endif
        for (int k = 1; k < WIN; k++) begin
            p2_point = 1'b1;
            for (int i = 0; i <= HOLD; i++) begin
                q.push_back(mk(4'd0, 4'(k), (i == HOLD), 1'b0, 1'b0, 2'b00, 1'b1));
                tick();
                p2_point = 1'b0;
                e = q.pop_front(); o = sample(); total++;
                if (o !== e) begin bad++; $display("FAIL p2_run[%0d,%0d]: actual=%h required=%h", k, i, o, e); end
            end
        end
        p2_point = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p1_point = (i == 5);
            if (i == 2) p2_point = 1'b1;
            q.push_back(mk(4'd0, 4'd3, 1'b0, 1'b0, 1'b1, 2'b10, pat[15-i]));
            tick();
            p1_point = 1'b0; p2_point = 1'b0;
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL game_over[%0d]: actual=%h required=%h", i, o, e); end
        end
        start = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        start = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL restart_go: actual=%h required=%h", o, e); end
    endtask

    task automatic test_reset_in_hold();
        obs_t e, o;
        p1_point = 1'b1;
        q.push_back(mk(4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1));
        tick();
        p1_point = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL pre_reset: actual=%h required=%h", o, e); end
        rst_n = 1'b0; p1_point = 1'b1;
        q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
        tick();
        rst_n = 1'b1; p1_point = 1'b0;
        e = q.pop_front(); o = sample(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_hold: actual=%h required=%h", o, e); end
        for (int i = 0; i <= HOLD; i++) begin
            q.push_back(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
            tick();
            e = q.pop_front(); o = sample(); total++;
            if (o !== e) begin bad++; $display("FAIL stay_idle[%0d]: actual=%h required=%h", i, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_point();
        test_hold_ignore();
        test_simultaneous();
        test_restart();
        test_win();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
